// File: rtl/data_memory_loader.sv
// Word-addressed data memory: combinational CPU read, clocked CPU write, streaming kernel-load port, power-up clear.
// Latency: rd is combinational; writes land at the rising edge; ld_done and err pulse one cycle after their cause.
// Backpressure: ld_ready is high only in LOAD; CPU writes are dropped silently while busy (CLEAR or LOAD).
module data_memory_loader #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 27,
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [LEN_W-1:0]  ld_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              busy,
    output logic              err
);

    // Pointer width covers 0..DEPTH-1; address comparisons are done at full ADDR_W width
    localparam int                PTR_W   = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST    = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [PTR_W-1:0]   clr_ptr;
    logic [PTR_W-1:0]   clr_ptr_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   cnt_nxt;
    logic               ld_ready_nxt;
    logic               ld_done_nxt;
    logic               err_nxt;

    // Single write port into the array, shared by clear engine, CPU and load stream
    logic               mem_we;
    logic [PTR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]  mem_wd;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               a_in_range;
    logic               base_in_range;
    logic               xfer;

    assign a_in_range    = (a < DEPTH_A);
    assign base_in_range = (ld_base < DEPTH_A);
    assign xfer          = ld_valid && ld_ready;

    // Out-of-range reads return zero so the array is never indexed past its end
    assign rd   = a_in_range ? mem[a[PTR_W-1:0]] : '0;
    assign busy = (state != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, datapath next values and array write selection
    always_comb begin
        state_nxt    = state;
        clr_ptr_nxt  = clr_ptr;
        ptr_nxt      = ptr;
        cnt_nxt      = cnt;
        ld_ready_nxt = ld_ready;
        ld_done_nxt  = 1'b0;
        // An out-of-range CPU write is flagged regardless of state; it never reaches the array
        err_nxt      = we && !a_in_range;
        mem_we       = 1'b0;
        mem_wa       = clr_ptr;
        mem_wd       = '0;

        case (state)
            ST_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = clr_ptr;
                mem_wd = '0;
                if (clr_ptr == LAST) begin
                    clr_ptr_nxt = '0;
                    state_nxt   = ST_IDLE;
                end else begin
                    clr_ptr_nxt = clr_ptr + 1'b1;
                end
            end

            ST_IDLE: begin
                if (we && a_in_range) begin
                    mem_we = 1'b1;
                    mem_wa = a[PTR_W-1:0];
                    mem_wd = wd;
                end
                // A bad base wins over a zero length: nothing about the burst is trusted
                if (ld_start) begin
                    if (!base_in_range) begin
                        err_nxt = 1'b1;
                    end else if (ld_len == '0) begin
                        ld_done_nxt = 1'b1;
                    end else begin
                        state_nxt    = ST_LOAD;
                        ptr_nxt      = ld_base[PTR_W-1:0];
                        cnt_nxt      = ld_len;
                        ld_ready_nxt = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (xfer) begin
                    mem_we  = 1'b1;
                    mem_wa  = ptr;
                    mem_wd  = ld_data;
                    ptr_nxt = (ptr == LAST) ? '0 : ptr + 1'b1;
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == LEN_W'(1)) begin
                        ld_ready_nxt = 1'b0;
                        ld_done_nxt  = 1'b1;
                        state_nxt    = ST_IDLE;
                    end
                end
            end

            default: begin
                state_nxt    = ST_CLEAR;
                clr_ptr_nxt  = '0;
                ld_ready_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and pulse registers; reset aborts any burst without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ptr  <= '0;
            ptr      <= '0;
            cnt      <= '0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            err      <= 1'b0;
        end else begin
            clr_ptr  <= clr_ptr_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
            ld_ready <= ld_ready_nxt;
            ld_done  <= ld_done_nxt;
            err      <= err_nxt;
        end
    end

    // Storage array; contents survive reset and are zeroed by the clear engine instead
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

endmodule
